cpu_control_unit: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. Fetches 16-bit instructions from the program memory, drives the shared combinational ALU (`alu_a`, `alu_b`, 3-bit `alu_sel`), owns a 4×8 register file and the zero/carry flags, and supports load-immediate, branch-if-zero and halt. It sits between program memory and the ALU and is the only master of the ALU select lines.

---
 rtl/cpu_control_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Owns the PC, instruction register, a 4x8 register file and the zero/carry
// flags, and is the sole master of the shared combinational ALU select lines.
// All outputs except dbg_data_o come straight from registers.
module cpu_control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic [7:0]  pc_o,
  input  logic [15:0] instr_i,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  output logic [2:0]  alu_sel_o,
  input  logic [7:0]  alu_result_i,
  input  logic        alu_carry_i,
  output logic        busy_o,
  output logic        halted_o,
  output logic        wb_valid_o,
  output logic [7:0]  wb_data_o,
  input  logic [1:0]  dbg_sel_i,
  output logic [7:0]  dbg_data_o,
  output logic        zero_flag_o,
  output logic        carry_flag_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_e;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_LDI = 2'b01;
  localparam logic [1:0] CLS_BRZ = 2'b10;
  localparam logic [2:0] OP_COMP = 3'b111;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  regs_q [4];
  logic [7:0]  regs_d [4];
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [2:0]  alu_sel_q, alu_sel_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
  logic        wb_valid_q, wb_valid_d;
  logic [7:0]  wb_data_q, wb_data_d;

  // State register; reset returns the sequencer to IDLE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-value logic for every register. Output-style
  // registers (ALU drive, busy, halted, wb_*) are computed from the state
  // being entered so they are valid for the whole cycle of that state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    regs_d     = regs_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    alu_a_d    = 8'h00;
    alu_b_d    = 8'h00;
    alu_sel_d  = 3'b000;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        state_d = S_DECODE;
      end

      S_DECODE: begin
        // instr_i is valid now; operands are read from instr_i directly so
        // the ALU drive is in place for the first EXECUTE cycle.
        ir_d = instr_i;
        case (instr_i[15:14])
          CLS_ALU: begin
            state_d   = S_EXECUTE;
            alu_a_d   = regs_q[instr_i[8:7]];
            alu_b_d   = regs_q[instr_i[6:5]];
            alu_sel_d = instr_i[13:11];
          end
          CLS_LDI: begin
            state_d    = S_WRITEBACK;
            wb_valid_d = 1'b1;
            wb_data_d  = instr_i[7:0];
          end
          CLS_BRZ: begin
            state_d = S_WRITEBACK;
          end
          default: begin
            state_d = S_HALTED;
          end
        endcase
      end

      S_EXECUTE: begin
        // Hold the ALU drive into WRITEBACK; the announced write value is the
        // ALU result for these held operands.
        state_d   = S_WRITEBACK;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        if (ir_q[13:11] != OP_COMP) begin
          wb_valid_d = 1'b1;
          wb_data_d  = alu_result_i;
        end else begin
          wb_valid_d = 1'b0;
        end
      end

      S_WRITEBACK: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 8'h01;
        case (ir_q[15:14])
          CLS_ALU: begin
            zero_d  = (alu_result_i == 8'h00);
            carry_d = alu_carry_i;
            if (ir_q[13:11] != OP_COMP) begin
              regs_d[ir_q[10:9]] = alu_result_i;
            end else begin
              regs_d = regs_q;
            end
          end
          CLS_LDI: begin
            regs_d[ir_q[10:9]] = ir_q[7:0];
          end
          CLS_BRZ: begin
            // The flag seen here already includes any preceding comp.
            if (zero_q) begin
              pc_d = ir_q[7:0];
            end else begin
              pc_d = pc_q + 8'h01;
            end
          end
          default: begin
            pc_d = pc_q + 8'h01;
          end
        endcase
      end

      S_HALTED: begin
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          zero_d  = 1'b0;
          carry_d = 1'b0;
        end else begin
          state_d = S_HALTED;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
               (state_d == S_EXECUTE) || (state_d == S_WRITEBACK);
    halted_d = (state_d == S_HALTED);
  end

  // Datapath and output registers; reset discards any in-flight write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 8'h00;
      end
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      alu_sel_q  <= 3'b000;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 8'h00;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign pc_o         = pc_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_sel_o    = alu_sel_q;
  assign busy_o       = busy_q;
  assign halted_o     = halted_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_data_o    = wb_data_q;
  assign zero_flag_o  = zero_q;
  assign carry_flag_o = carry_q;
  assign dbg_data_o   = regs_q[dbg_sel_i];

endmodule

// File: tb/tb_cpu_control_unit.sv
// Testbench for cpu_control_unit: program memory and ALU models, directed
// programs, and a write-back scoreboard checked by an independent monitor.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        busy, halted, wb_valid;
  logic [7:0]  wb_data;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;
  logic        zero_flag, carry_flag;

  logic [15:0] mem [256];
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;
  logic [8:0]  tmp9;
  logic [15:0] prod;
  logic [7:0]  rd_val;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  cpu_control_unit #(.RESET_PC(8'h00)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .pc_o(pc), .instr_i(instr),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
    .alu_result_i(alu_result), .alu_carry_i(alu_carry),
    .busy_o(busy), .halted_o(halted), .wb_valid_o(wb_valid), .wb_data_o(wb_data),
    .dbg_sel_i(dbg_sel), .dbg_data_o(dbg_data),
    .zero_flag_o(zero_flag), .carry_flag_o(carry_flag)
  );

  // Program memory: data appears one cycle after the address.
  always @(posedge clk) instr <= mem[pc];

  // Combinational ALU model.
  always_comb begin
    tmp9 = 9'h000;
    prod = 16'h0000;
    alu_result = 8'h00;
    alu_carry = 1'b0;
    case (alu_sel)
      3'b000: begin tmp9 = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = tmp9[7:0]; alu_carry = tmp9[8]; end
      3'b001: begin tmp9 = {1'b0, alu_a} - {1'b0, alu_b}; alu_result = tmp9[7:0]; alu_carry = tmp9[8]; end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: begin prod = alu_a * alu_b; alu_result = prod[7:0]; alu_carry = |prod[15:8]; end
      3'b110: alu_result = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
      default: begin alu_result = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
    endcase
  end

  function automatic logic [15:0] f_alu(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
    return {2'b00, op, rd, rs1, rs2, 5'b00000};
  endfunction
  function automatic logic [15:0] f_ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {2'b01, 3'b000, rd, 1'b0, imm};
  endfunction
  function automatic logic [15:0] f_brz(input logic [7:0] tgt);
    return {2'b10, 6'b000000, tgt};
  endfunction
  function automatic logic [15:0] f_halt();
    return 16'hC000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every write-back pulse pops one expected value.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got wb_data %0h, nothing expected", wb_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (wb_data !== mon_exp) begin
          errors++;
          $display("FAIL wb_data: got %0h, expected %0h", wb_data, mon_exp);
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = f_halt();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Raise start, let the sampling edge pass (cycle 0), hold for 'hold' cycles.
  task automatic start_pulse(input int hold);
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    if (hold > 1) step(hold - 1);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int exp_cyc);
    while (halted !== 1'b1 && cyc < 300) step(1);
    check(name, cyc, exp_cyc);
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [7:0] v);
    dbg_sel = idx;
    #1;
    v = dbg_data;
  endtask

  task automatic load_basic(input logic [2:0] op);
    clear_mem();
    mem[0] = f_ldi(2'd0, 8'd5);
    mem[1] = f_ldi(2'd1, 8'd3);
    mem[2] = f_alu(op, 2'd2, 2'd0, 2'd1);
    mem[3] = f_halt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op_exp [7];
    logic [7:0] comp_b [2];
    logic [7:0] comp_pc [2];
    int         comp_cyc [2];
    op_exp = '{8'd8, 8'd2, 8'd1, 8'd7, 8'd6, 8'd15, 8'd1};
    comp_b = '{8'd5, 8'd3};
    comp_pc = '{8'h20, 8'h05};
    comp_cyc = '{15, 18};

    reset = 1'b1;
    start = 1'b0;
    dbg_sel = 2'd0;
    clear_mem();
    do_reset();

    // Reset state
    check("rst_pc", pc, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, 8'h00);
    check("rst_alu", {alu_a, alu_b, alu_sel}, 19'h0);
    check("rst_flags", {zero_flag, carry_flag}, 2'b00);
    for (int r = 0; r < 4; r++) begin
      read_reg(r[1:0], rd_val);
      check("rst_reg", rd_val, 8'h00);
    end

    // Basic program, start held high for three cycles (starts once)
    load_basic(3'b000);
    exp_q.push_back(8'd5);
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd8);
    start_pulse(3);
    check("ldi_wb_cycle", wb_valid, 1'b1);
    step(1);
    read_reg(2'd0, rd_val);
    check("dbg_after_wb", rd_val, 8'd5);
    step(5);
    check("exec_sel_add", alu_sel, 3'b000);
    check("exec_operands", {alu_a, alu_b}, {8'd5, 8'd3});
    check("exec_busy", busy, 1'b1);
    wait_halt("halt_latency", 12);
    read_reg(2'd2, rd_val);
    check("add_r2", rd_val, 8'd8);

    // Remaining ALU ops 001..110
    for (int op = 1; op < 7; op++) begin
      do_reset();
      load_basic(op[2:0]);
      exp_q.push_back(8'd5);
      exp_q.push_back(8'd3);
      exp_q.push_back(op_exp[op]);
      start_pulse(1);
      step(8);
      check("exec_sel", alu_sel, op[2:0]);
      wait_halt("op_halt", 12);
      read_reg(2'd2, rd_val);
      check("op_r2", rd_val, op_exp[op]);
    end

    // comp then BRZ, taken (r1=5) and not taken (r1=3)
    for (int k = 0; k < 2; k++) begin
      do_reset();
      clear_mem();
      mem[0] = f_ldi(2'd0, 8'd5);
      mem[1] = f_ldi(2'd1, comp_b[k]);
      mem[2] = f_alu(3'b111, 2'd3, 2'd0, 2'd1);
      mem[3] = f_brz(8'h20);
      mem[4] = f_ldi(2'd3, 8'hAA);
      mem[5] = f_halt();
      mem[8'h20] = f_halt();
      exp_q.push_back(8'd5);
      exp_q.push_back(comp_b[k]);
      if (k == 1) exp_q.push_back(8'hAA);
      start_pulse(1);
      step(9);
      check("comp_no_wb", wb_valid, 1'b0);
      check("comp_sel", alu_sel, 3'b111);
      step(1);
      check("comp_zero", zero_flag, (k == 0) ? 1'b1 : 1'b0);
      read_reg(2'd3, rd_val);
      check("comp_no_write", rd_val, 8'h00);
      step(3);
      check("brz_pc", pc, (k == 0) ? 8'h20 : 8'h04);
      wait_halt("brz_halt", comp_cyc[k]);
      check("brz_halt_pc", pc, comp_pc[k]);
    end

    // PC wrap after an LDI at 8'hFF
    do_reset();
    clear_mem();
    mem[0] = f_alu(3'b111, 2'd0, 2'd0, 2'd0);
    mem[1] = f_brz(8'hFF);
    mem[8'hFF] = f_ldi(2'd1, 8'h77);
    exp_q.push_back(8'h77);
    start_pulse(1);
    step(7);
    check("wrap_pc_ff", pc, 8'hFF);
    step(3);
    check("wrap_pc_00", pc, 8'h00);
    read_reg(2'd1, rd_val);
    check("wrap_r1", rd_val, 8'h77);

    // Reset during EXECUTE of an ADD
    do_reset();
    load_basic(3'b000);
    exp_q.push_back(8'd5);
    exp_q.push_back(8'd3);
    start_pulse(1);
    step(8);
    check("pre_rst_exec", {alu_a, alu_b}, {8'd5, 8'd3});
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_exec_busy", busy, 1'b0);
    check("rst_exec_pc", pc, 8'h00);
    check("rst_exec_alu", {alu_a, alu_b, alu_sel}, 19'h0);
    for (int r = 0; r < 4; r++) begin
      read_reg(r[1:0], rd_val);
      check("rst_exec_reg", rd_val, 8'h00);
    end
    step(3);
    check("rst_exec_idle", busy, 1'b0);

    // Restart from HALTED: flags cleared, registers kept, busy start ignored
    do_reset();
    clear_mem();
    mem[0] = f_ldi(2'd0, 8'd5);
    mem[1] = f_ldi(2'd1, 8'd3);
    mem[2] = f_alu(3'b000, 2'd2, 2'd0, 2'd1);
    mem[3] = f_ldi(2'd3, 8'hFD);
    mem[4] = f_alu(3'b000, 2'd3, 2'd3, 2'd1);
    mem[5] = f_halt();
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.push_back(8'd5);
      exp_q.push_back(8'd3);
      exp_q.push_back(8'd8);
      exp_q.push_back(8'hFD);
      exp_q.push_back(8'h00);
    end
    start_pulse(1);
    wait_halt("restart_first_halt", 19);
    check("pre_restart_flags", {zero_flag, carry_flag}, 2'b11);
    read_reg(2'd3, rd_val);
    check("rd_eq_rs1", rd_val, 8'h00);
    check("halted_pc", pc, 8'h05);
    start_pulse(1);
    check("restart_pc", pc, 8'h00);
    check("restart_flags", {zero_flag, carry_flag}, 2'b00);
    check("restart_state", {busy, halted}, 2'b10);
    read_reg(2'd2, rd_val);
    check("restart_r2_kept", rd_val, 8'd8);
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_halt("restart_second_halt", 19);

    step(2);
    check("sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
